stopwatch_timekeeper: RTL and testbench
=======================================

# stopwatch_timekeeper

Timekeeping core of the stopwatch. Divides the system clock into one-second ticks and keeps an mm:ss count (00:00–59:59). It drives the `minutes` and `seconds` inputs of `seven_segment_driver` directly. It takes two button inputs, `start_stop` and `clear`, which are synchronised and edge-detected inside this block.

## Interface
- `TICKS_PER_SECOND`, default 50_000_000: system clock cycles per counted second. Minimum 2. Benches use 4.
- `clock`  in  1  system clock (50 MHz); all state changes on the rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start_stop`  in  1  asynchronous level from a button already debounced upstream; each rising edge toggles run/pause
- `clear`  in  1  asynchronous level from a button already debounced upstream; rising edge zeroes the count and stops
- `minutes`  out  6  elapsed minutes, 0–59, binary; connects to `seven_segment_driver.minutes`
- `seconds`  out  6  elapsed seconds, 0–59, binary; connects to `seven_segment_driver.seconds`
- `running`  out  1  high while in the RUNNING state
- `rollover`  out  1  one-cycle pulse when the count wraps from 59:59 to 00:00

## Operation
- **Input conditioning**
  - Each button passes through a 2-flop synchroniser (s1, s2) and then a history flop (s3).
  - The event signal is s2 & ~s3, which is high for exactly one cycle per rising edge.
  - Holding a button produces no further events.
- **State machine** with states IDLE, RUNNING and PAUSED:
  - IDLE + start_stop event -> RUNNING
  - RUNNING + start_stop event -> PAUSED
  - PAUSED + start_stop event -> RUNNING
  - any state + clear event -> IDLE, with the prescaler, `minutes` and `seconds` all set to 0
- **Priority**
  - A clear event and a start_stop event in the same cycle: clear wins. The block ends in IDLE, zeroed.
  - A clear event coinciding with a tick: clear wins. No increment and no `rollover`.
- **Prescaler**
  - Width is $clog2(TICKS_PER_SECOND).
  - It increments on every edge where the pre-edge state is RUNNING.
  - At TICKS_PER_SECOND-1 it wraps to 0 and generates an internal tick.
  - In PAUSED it holds its value, so a resume keeps the fractional second.
  - In IDLE it is 0.
- **Count update on a tick**
  - If `seconds` < 59: `seconds` increments.
  - If `seconds` == 59 and `minutes` < 59: `seconds` goes to 0 and `minutes` increments.
  - If the count is 59:59: both go to 0, `rollover` is 1 for that cycle, and the state stays RUNNING.
- `minutes` and `seconds` never leave the range 0–59. The arithmetic is 6-bit compare-and-reset; there is no modulo logic.

## Timing
- **Reset**
  - Driving `reset` low immediately forces, without waiting for a clock edge: state IDLE, prescaler 0, `minutes`=0, `seconds`=0, `running`=0, `rollover`=0, and all synchroniser/history flops 0.
  - Operation resumes on the first clock edge after `reset` goes high.
  - A reset mid-count loses the count; nothing is retained.
- **Button latency**
  - Condition: the button is high at setup time before edge 1.
  - s2 goes high after edge 2; the state/clear action registers at edge 3.
  - `running` changes after edge 3.
- **First second**
  - If the state becomes RUNNING at edge E, the prescaler reaches TICKS_PER_SECOND-1 at edge E+TICKS_PER_SECOND-1.
  - `seconds` becomes 1 after edge E+TICKS_PER_SECOND.
  - Every subsequent second takes exactly TICKS_PER_SECOND cycles.
- **Output timing**
  - `minutes` and `seconds` are registered outputs. Both change on the same edge, with no glitches and no intermediate values.
  - `rollover` is registered and is asserted in the cycle in which the outputs read 00:00.
- `running` is a registered decode of the state, with no combinational path from the buttons.

## Test plan
- **Reset:** hold `reset` low with buttons toggling -> all outputs 0, `running`=0. Then release and leave the buttons idle for 100 cycles -> outputs stay 0.
- **Start and count** (TICKS_PER_SECOND=4): pulse `start_stop` high for 1 cycle.
  - `running`=1 after the 3rd edge.
  - `seconds`=1 exactly 4 cycles later.
  - After 240 running cycles, `minutes`=1 and `seconds`=0.
- **Pause/resume preserves phase:**
  - Start, then run 6 cycles -> `seconds`=1.
  - Pause, then hold 50 cycles -> outputs frozen, `running`=0.
  - Resume -> `seconds`=2 after a total of 8 running cycles.
- **Rollover:** run 14400 cycles (3600 s).
  - 59:59 -> 00:00.
  - `rollover` is high for exactly 1 cycle.
  - `running` stays 1.
  - `seconds`=1 after 4 more cycles.
- **Clear priority:** while RUNNING at 12:34, raise `clear` and `start_stop` on the same cycle -> the block goes to IDLE at 00:00 with `running`=0 and no `rollover`.
- **Asynchronous reset mid-count:** assert `reset` low between clock edges at 03:07 -> outputs read 0 before the next edge.

Source files
------------

// File: rtl/stopwatch_timekeeper.sv
// Stopwatch timekeeping core: button conditioning, run/pause FSM, one-second
// prescaler and mm:ss counter feeding the seven-segment driver.
module stopwatch_timekeeper #(
  parameter int unsigned TICKS_PER_SECOND = 50_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       clear,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       running,
  output logic       rollover
);

  localparam int unsigned PW = (TICKS_PER_SECOND > 1) ? $clog2(TICKS_PER_SECOND) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(TICKS_PER_SECOND - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUNNING,
    S_PAUSED
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [2:0]    r_ss_sync;
  logic [2:0]    r_clr_sync;
  logic [PW-1:0] r_presc;
  logic [5:0]    r_minutes;
  logic [5:0]    r_seconds;
  logic          r_running;
  logic          r_rollover;
  logic          w_ss_evt;
  logic          w_clr_evt;
  logic          w_tick;
  logic          w_sec_last;
  logic          w_min_last;

  // Bit 0 = s1, bit 1 = s2, bit 2 = history flop s3.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ss_sync  <= '0;
      r_clr_sync <= '0;
    end else begin
      r_ss_sync  <= {r_ss_sync[1:0], start_stop};
      r_clr_sync <= {r_clr_sync[1:0], clear};
    end
  end

  assign w_ss_evt  = r_ss_sync[1] & ~r_ss_sync[2];
  assign w_clr_evt = r_clr_sync[1] & ~r_clr_sync[2];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (w_clr_evt) begin
      w_next = S_IDLE;
    end else if (w_ss_evt) begin
      case (r_state)
        S_IDLE:    w_next = S_RUNNING;
        S_RUNNING: w_next = S_PAUSED;
        S_PAUSED:  w_next = S_RUNNING;
        default:   w_next = S_IDLE;
      endcase
    end
  end

  assign w_tick     = (r_state == S_RUNNING) && (r_presc == P_LAST);
  assign w_sec_last = (r_seconds == 6'd59);
  assign w_min_last = (r_minutes == 6'd59);

  // Clear outranks both the prescaler advance and any coincident tick.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_presc    <= '0;
      r_minutes  <= '0;
      r_seconds  <= '0;
      r_running  <= 1'b0;
      r_rollover <= 1'b0;
    end else begin
      r_rollover <= 1'b0;
      r_running  <= (w_next == S_RUNNING);
      if (w_clr_evt) begin
        r_presc   <= '0;
        r_minutes <= '0;
        r_seconds <= '0;
      end else if (r_state == S_RUNNING) begin
        if (w_tick) begin
          r_presc <= '0;
          if (!w_sec_last) begin
            r_seconds <= r_seconds + 6'd1;
          end else begin
            r_seconds <= '0;
            if (!w_min_last) begin
              r_minutes <= r_minutes + 6'd1;
            end else begin
              r_minutes  <= '0;
              r_rollover <= 1'b1;
            end
          end
        end else begin
          r_presc <= r_presc + 1'b1;
        end
      end
    end
  end

  assign minutes  = r_minutes;
  assign seconds  = r_seconds;
  assign running  = r_running;
  assign rollover = r_rollover;

endmodule

// File: tb/tb_stopwatch_timekeeper.sv
// Bench for stopwatch_timekeeper: elapsed-time model compared every cycle,
// plus directed pins of hand-computed mm:ss values.
module tb_stopwatch_timekeeper;

  localparam int unsigned TPS = 4;

  logic       clock      = 1'b0;
  logic       reset      = 1'b1;
  logic       start_stop = 1'b0;
  logic       clear      = 1'b0;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       running;
  logic       rollover;

  stopwatch_timekeeper #(.TICKS_PER_SECOND(TPS)) dut (
    .clock      (clock),
    .reset      (reset),
    .start_stop (start_stop),
    .clear      (clear),
    .minutes    (minutes),
    .seconds    (seconds),
    .running    (running),
    .rollover   (rollover)
  );

  always #5 clock = ~clock;

  // Model: mode 0 idle, 1 run, 2 pause; time kept as total seconds + fraction.
  int m_mode  = 0;
  int m_frac  = 0;
  int m_total = 0;
  bit m_roll  = 1'b0;
  bit ss_h1 = 1'b0, ss_h2 = 1'b0, ss_h3 = 1'b0;
  bit cl_h1 = 1'b0, cl_h2 = 1'b0, cl_h3 = 1'b0;
  bit m_ss_e, m_cl_e;

  // A button level sampled at edge k-2 (and low at k-3) acts at edge k.
  initial forever begin
    @(posedge clock or negedge reset);
    if (!reset) begin
      m_mode = 0; m_frac = 0; m_total = 0; m_roll = 1'b0;
      ss_h1 = 1'b0; ss_h2 = 1'b0; ss_h3 = 1'b0;
      cl_h1 = 1'b0; cl_h2 = 1'b0; cl_h3 = 1'b0;
    end else begin
      m_ss_e = ss_h2 && !ss_h3;
      m_cl_e = cl_h2 && !cl_h3;
      ss_h3 = ss_h2; ss_h2 = ss_h1; ss_h1 = start_stop;
      cl_h3 = cl_h2; cl_h2 = cl_h1; cl_h1 = clear;
      m_roll = 1'b0;
      if (m_cl_e) begin
        m_mode = 0; m_frac = 0; m_total = 0;
      end else begin
        if (m_mode == 1) begin
          m_frac = m_frac + 1;
          if (m_frac == TPS) begin
            m_frac  = 0;
            m_total = m_total + 1;
            if (m_total == 3600) begin
              m_total = 0;
              m_roll  = 1'b1;
            end
          end
        end
        if (m_ss_e) m_mode = (m_mode == 1) ? 2 : 1;
      end
    end
  end

  int n_cmp = 0;
  int n_err = 0;
  int pin_seq = 0;
  int pin_done = 0;
  int pin_m, pin_s, pin_r, pin_ro;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  initial forever begin
    @(negedge clock);
    chk("minutes",  {26'd0, minutes},  m_total / 60);
    chk("seconds",  {26'd0, seconds},  m_total % 60);
    chk("running",  {31'd0, running},  {31'd0, m_mode == 1});
    chk("rollover", {31'd0, rollover}, {31'd0, m_roll});
    if (pin_seq != pin_done) begin
      pin_done = pin_seq;
      chk("pin_minutes",  {26'd0, minutes},  pin_m);
      chk("pin_seconds",  {26'd0, seconds},  pin_s);
      chk("pin_running",  {31'd0, running},  pin_r);
      chk("pin_rollover", {31'd0, rollover}, pin_ro);
      chk("model_minutes", m_total / 60, pin_m);
      chk("model_seconds", m_total % 60, pin_s);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic pin(input int m, input int s, input int r, input int ro);
    pin_m = m; pin_s = s; pin_r = r; pin_ro = ro;
    pin_seq++;
  endtask

  // One-cycle press; returns just after the edge where the action registers.
  task automatic press(input logic s, input logic c);
    start_stop = s; clear = c;
    cyc(1);
    start_stop = 1'b0; clear = 1'b0;
    cyc(2);
  endtask

  initial begin
    #1 reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      start_stop = i[0];
      clear      = ~i[0];
      cyc(1);
    end
    pin(0, 0, 0, 0);
    cyc(1);
    start_stop = 1'b0; clear = 1'b0;
    reset = 1'b1;
    cyc(100);
    pin(0, 0, 0, 0);

    // Start and count
    start_stop = 1'b1; cyc(1);
    start_stop = 1'b0; cyc(1);
    pin(0, 0, 0, 0);
    cyc(1); pin(0, 0, 1, 0);
    cyc(3); pin(0, 0, 1, 0);
    cyc(1); pin(0, 1, 1, 0);
    cyc(235); pin(0, 59, 1, 0);
    cyc(1); pin(1, 0, 1, 0);
    press(1'b0, 1'b1); pin(0, 0, 0, 0);

    // Pause/resume keeps the fractional second
    press(1'b1, 1'b0); pin(0, 0, 1, 0);
    cyc(3);
    press(1'b1, 1'b0); pin(0, 1, 0, 0);
    cyc(50); pin(0, 1, 0, 0);
    press(1'b1, 1'b0); pin(0, 1, 1, 0);
    cyc(1); pin(0, 1, 1, 0);
    cyc(1); pin(0, 2, 1, 0);
    press(1'b0, 1'b1); pin(0, 0, 0, 0);

    // Rollover after one hour
    press(1'b1, 1'b0);
    cyc(14399); pin(59, 59, 1, 0);
    cyc(1); pin(0, 0, 1, 1);
    cyc(1); pin(0, 0, 1, 0);
    cyc(3); pin(0, 1, 1, 0);
    press(1'b0, 1'b1); pin(0, 0, 0, 0);

    // Clear and start_stop together, landing on a tick edge
    press(1'b1, 1'b0);
    cyc(3017); pin(12, 34, 1, 0);
    press(1'b1, 1'b1); pin(0, 0, 0, 0);
    cyc(1); pin(0, 0, 0, 0);

    // Asynchronous reset between edges at 03:07
    press(1'b1, 1'b0);
    cyc(748); pin(3, 7, 1, 0);
    cyc(1);
    #1 reset = 1'b0;
    pin(0, 0, 0, 0);
    cyc(1);
    reset = 1'b1;
    cyc(5); pin(0, 0, 0, 0);

    @(negedge clock);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
